// File: rtl/instr_encoder.sv
// Program-load front end: packs instruction fields into 32-bit words, buffers them
// in a small FIFO and streams them to instruction memory at an auto-incrementing address.
module instr_encoder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned BASE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rd2,
  input  logic [4:0]        rd1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rs1,
  input  logic [15:0]       imm,
  input  logic [7:0]        addr,
  output logic              im_we,
  input  logic              im_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_data,
  output logic [ADDR_W:0]   words_written,
  output logic              done,
  output logic              err_illegal,
  output logic              err_overflow
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t              state, next_state;
  logic [31:0]         mem [DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [PW:0]         count;
  logic [ADDR_W-1:0]   wr_addr;
  logic                addr_full;
  logic [31:0]         word;
  logic                active, empty, full, legal, accept, push, pop, wr_done;

  always_comb begin
    word        = '0;
    word[31:26] = opcode;
    if (opcode == 6'h00) begin
      word[25:21] = rd2;
      word[15:0]  = imm;
    end else if (opcode == 6'h01) begin
      word[25:21] = rd2;
      word[4:0]   = rs2;
    end else if (opcode == 6'h02) begin
      word[25:21] = rd2;
      word[7:0]   = addr;
    end else if (opcode == 6'h03) begin
      word[25:18] = addr;
      word[4:0]   = rs2;
    end else begin
      word[25:21] = rd2;
      word[20:16] = rd1;
      word[9:5]   = rs2;
      word[4:0]   = rs1;
    end
  end

  // Once the top address has been written, queued words are discarded instead of written.
  always_comb begin
    active   = (state == LOAD) || (state == FLUSH);
    empty    = (count == '0);
    full     = (count == (PW+1)'(DEPTH));
    legal    = (opcode <= 6'h11);
    in_ready = (state == LOAD) && !full;
    accept   = in_valid && in_ready;
    push     = accept && legal;
    im_we    = active && !empty && !addr_full;
    wr_done  = im_we && im_ready;
    pop      = active && !empty && (addr_full || im_ready);
    im_data  = empty ? '0 : mem[rd_ptr];
    im_addr  = wr_addr;
    done     = (state == DONE);
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LOAD;
      LOAD:    if (accept && in_last) next_state = FLUSH;
      FLUSH:   if (empty || (count == (PW+1)'(1) && pop)) next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      wr_addr       <= ADDR_W'(BASE);
      addr_full     <= 1'b0;
      words_written <= '0;
      err_illegal   <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && start) begin
        wr_addr       <= ADDR_W'(BASE);
        addr_full     <= 1'b0;
        words_written <= '0;
        err_illegal   <= 1'b0;
        err_overflow  <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (wr_done) begin
        words_written <= words_written + 1'b1;
        if (wr_addr == '1) addr_full <= 1'b1;
        else               wr_addr   <= wr_addr + 1'b1;
      end
      if (pop && addr_full)   err_overflow <= 1'b1;
      if (accept && !legal)   err_illegal  <= 1'b1;
    end
  end

endmodule
